// File: rtl/bloom_pkg.sv
// Shared types for the Bloom pattern-search front end.
package bloom_pkg;

   localparam int BYTE_W = 8;

   // Callers build their window as a packed array of these: byte_t [N-1:0].
   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [1:0] {
      WIN_IDLE,
      WIN_FILL,
      WIN_RUN
   } win_state_t;

endpackage

// File: rtl/byte_window_out_reg.sv
// Single-entry valid/ready output register for the byte window.
// A new window may only be loaded when the slot is empty or being consumed,
// so contents are stable while valid is held against backpressure.
module byte_window_out_reg
   import bloom_pkg::*;
#(
   parameter int BYTES_CNT = 15,
   parameter int POS_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  byte_t [BYTES_CNT-1:0]    next_window,
   input  logic                     next_last,
   input  logic [POS_W-1:0]         next_pos,
   input  logic                     consume,
   output byte_t [BYTES_CNT-1:0]    window,
   output logic                     valid,
   output logic                     last,
   output logic [POS_W-1:0]         pos
);

   // Load replaces the held window; a consume without a load empties the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         window <= '0;
         valid  <= 1'b0;
         last   <= 1'b0;
         pos    <= '0;
      end else if (load) begin
         window <= next_window;
         valid  <= 1'b1;
         last   <= next_last;
         pos    <= next_pos;
      end else if (consume) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/byte_window_shifter.sv
// Sliding window of the last BYTES_CNT stream bytes, emitted once per
// accepted byte after the window has filled within the current packet.
// Index 0 of window_o is the oldest byte, BYTES_CNT-1 the newest.
module byte_window_shifter
   import bloom_pkg::*;
#(
   parameter int BYTES_CNT = 15,
   parameter int POS_W     = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [BYTE_W-1:0]                     data_i,
   input  logic                                  valid_i,
   input  logic                                  sop_i,
   input  logic                                  eop_i,
   output logic                                  ready_o,
   output logic [BYTES_CNT-1:0][BYTE_W-1:0]      window_o,
   output logic                                  window_valid_o,
   input  logic                                  window_ready_i,
   output logic                                  window_last_o,
   output logic [POS_W-1:0]                      window_pos_o,
   output logic                                  err_o
);

   localparam int FILL_W = $clog2(BYTES_CNT + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(BYTES_CNT);

   win_state_t               state, state_n;
   logic [FILL_W-1:0]        fill, fill_n, fill_inc;
   logic [POS_W-1:0]         pos, pos_n;
   logic                     err, err_n;
   logic                     shift, produce, accept;
   byte_t [BYTES_CNT-1:0]    win, win_next;

   function automatic logic [POS_W-1:0] sat_pos_inc(input logic [POS_W-1:0] v);
      return (v == {POS_W{1'b1}}) ? v : v + POS_W'(1);
   endfunction

   function automatic logic [FILL_W-1:0] sat_fill_inc(input logic [FILL_W-1:0] v);
      return (v == FILL_FULL) ? v : v + FILL_W'(1);
   endfunction

   assign ready_o  = !window_valid_o || window_ready_i;
   assign accept   = valid_i && ready_o;
   assign win_next = {data_i, win[BYTES_CNT-1:1]};
   assign err_o    = err;

   // Control state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= WIN_IDLE;
         fill  <= '0;
         pos   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         fill  <= fill_n;
         pos   <= pos_n;
         err   <= err_n;
      end
   end

   // Shift register; old bytes are never cleared, fill alone qualifies them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win <= '0;
      end else if (shift) begin
         win <= win_next;
      end
   end

   // Next-state: packet tracking, fill counting and window production.
   always_comb begin
      state_n  = state;
      fill_n   = fill;
      pos_n    = pos;
      err_n    = 1'b0;
      shift    = 1'b0;
      produce  = 1'b0;
      fill_inc = sat_fill_inc(fill);
      if (accept) begin
         if (sop_i) begin
            // A start byte always (re)opens a packet; a single-byte packet
            // can never fill a window, so it is dropped straight back to idle.
            shift   = 1'b1;
            pos_n   = '0;
            fill_n  = eop_i ? '0 : FILL_W'(1);
            state_n = eop_i ? WIN_IDLE : WIN_FILL;
         end else if (state == WIN_IDLE) begin
            err_n = 1'b1;
         end else begin
            shift   = 1'b1;
            pos_n   = sat_pos_inc(pos);
            produce = (fill_inc == FILL_FULL);
            if (eop_i) begin
               fill_n  = '0;
               state_n = WIN_IDLE;
            end else begin
               fill_n  = fill_inc;
               state_n = produce ? WIN_RUN : WIN_FILL;
            end
         end
      end
   end

   byte_window_out_reg #(
      .BYTES_CNT (BYTES_CNT),
      .POS_W     (POS_W)
   ) u_out_reg (
      .clk         (clk_i),
      .rst         (rst_i),
      .load        (produce),
      .next_window (win_next),
      .next_last   (eop_i),
      .next_pos    (pos_n),
      .consume     (window_ready_i),
      .window      (window_o),
      .valid       (window_valid_o),
      .last        (window_last_o),
      .pos         (window_pos_o)
   );

endmodule
